// File: rtl/slt_serial_pkg.sv
// Shared types and defaults for the bit-serial set-on-less-than engine.
package slt_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slt_state_t;

  localparam int unsigned SLT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/full_adder_bit.sv
// Single gate-level full-adder cell; the entire arithmetic datapath of the serial engine.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic axb, ab, cab;

  xor g_x0 (axb, a, b);
  xor g_x1 (s, axb, cin);
  and g_a0 (ab, a, b);
  and g_a1 (cab, axb, cin);
  or  g_o0 (cout, ab, cab);

endmodule

// File: rtl/slt_serial_unit.sv
// Bit-serial slt/sltu flag: computes a + ~b + 1 LSB first, one bit per clock.
module slt_serial_unit
  import slt_serial_pkg::*;
#(
  parameter int unsigned WIDTH = SLT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  slt_state_t       state;
  logic [WIDTH-1:0] sa, sb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sgn;
  logic             s, c_out;

  full_adder_bit u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (carry),
    .s   (s),
    .cout(c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sgn   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= ~b;
            sgn   <= signed_mode;
            carry <= 1'b1;
            cnt   <= '0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          // Final step: sign bit s and overflow carry_in ^ c_out are both live here.
          if (cnt == LAST) begin
            lt    <= sgn ? (s ^ (carry ^ c_out)) : ~c_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slt_serial_unit.sv
// Self-checking bench for slt_serial_unit: cycle-level reference model plus directed and random operations.
module tb_slt_serial_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, lt;

  int checks = 0;
  int errors = 0;

  slt_serial_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .lt         (lt)
  );

  always #5 clk = ~clk;

  function automatic bit ref_lt(input logic [W-1:0] x, input logic [W-1:0] y, input bit sg);
    if (sg) return $signed(x) < $signed(y);
    return x < y;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an operation accepted when idle completes WIDTH edges later.
  bit m_busy = 0, m_done = 0, m_lt = 0, m_pend = 0;
  int m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_lt = 0; m_rem = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1; m_lt = m_pend;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_busy = 1; m_rem = W; m_lt = 0;
        m_pend = ref_lt(a, b, signed_mode);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("lt",   {31'b0, lt},   {31'b0, m_lt});
  end

  // Drive operands mid-cycle; returns #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input bit sg);
    a = x; b = y; signed_mode = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns #1 after the done edge, so a following launch is back-to-back.
  task automatic finish_op(input string nm, input int n0, input bit exp_lt);
    int n = n0;
    while (!done && n < 3 * W) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_lt"}, {31'b0, lt}, {31'b0, exp_lt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    bit sg;
    logic [W-1:0] edges [6];
    edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_lt",   {31'b0, lt},   32'd0);

    launch(32'd5, 32'd7, 1'b1);               finish_op("s5_7", 0, 1'b1);
    @(posedge clk); #1;
    launch(32'h1234, 32'h1234, 1'b1);         finish_op("eq", 0, 1'b0);
    @(posedge clk); #1;
    launch(32'hFFFF_FFFF, 32'd1, 1'b1);       finish_op("s_m1_1", 0, 1'b1);
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);       finish_op("u_max_1_b2b", 0, 1'b0);
    launch(32'h8000_0000, 32'h7FFF_FFFF, 1'b1); finish_op("s_ovf", 0, 1'b1);
    launch(32'h8000_0000, 32'h7FFF_FFFF, 1'b0); finish_op("u_ovf", 0, 1'b0);
    launch(32'h7FFF_FFFF, 32'h8000_0000, 1'b1); finish_op("s_ovf_rev", 0, 1'b0);

    // Second start lands 10 edges into the run and must be ignored.
    @(posedge clk); #1;
    launch(32'd9, 32'd3, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    a = 32'd0; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("ignore_start", 10, 1'b0);
    @(posedge clk); #1;
    chk("single_done", {31'b0, done}, 32'd0);

    launch(32'd2, 32'd9, 1'b1);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_lt",   {31'b0, lt},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    launch(32'd2, 32'd3, 1'b1);               finish_op("after_rst", 0, 1'b1);

    for (int i = 0; i < 50; i++) begin
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      sg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      launch(x, y, sg);
      finish_op("rand", 0, ref_lt(x, y, sg));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
